// File: rtl/regfile_pkg.sv
// Shared size encodings and the extend/narrow helper
// for the multiport register file.
package regfile_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Widest register the helper handles; callers truncate.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] size_ext(
    input logic [MAX_W-1:0] d,
    input logic [1:0]       sz,
    input logic             sext
  );
    logic [MAX_W-1:0] r;
    r = d;
    case (sz)
      SZ_HALF: r = {{(MAX_W-16){sext & d[15]}}, d[15:0]};
      SZ_BYTE: r = {{(MAX_W-8){sext & d[7]}}, d[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile_extend.sv
// Combinational byte/half/word extender.
// Ports: data_i, size_i, sext_i in; data_o out.
module regfile_extend
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  output logic [DATA_W-1:0] data_o
);

  logic [MAX_W-1:0] wide;

  always_comb wide = size_ext(MAX_W'(data_i), size_i, sext_i);

  assign data_o = wide[DATA_W-1:0];

  generate
    if (DATA_W < MAX_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^wide[MAX_W-1:DATA_W];
    end
  endgenerate

endmodule

// File: rtl/regfile_multiport.sv
// N-read / 1-write register file with sized accesses.
// Ports: clk, rst_n, rd_en/addr/size -> rd_data (1-cycle),
// wr_en/addr/data/size/sext. Macro: REGFILE_WB_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  input  logic [NUM_RD*2-1:0]      rd_size,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [1:0]               wr_size,
  input  logic                     wr_sext
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] wr_ext;
  logic              wr_ok;

  logic [DATA_W-1:0] src       [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];

  regfile_extend #(.DATA_W(DATA_W)) u_wr_ext (
    .data_i (wr_data),
    .size_i (wr_size),
    .sext_i (wr_sext),
    .data_o (wr_ext)
  );

  assign wr_ok = wr_en
              && ({1'b0, wr_addr} < DEPTH_C)
              && !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] a;
      a      = rd_addr[i*AW +: AW];
      src[i] = '0;
      if ({1'b0, a} < DEPTH_C) src[i] = regs_q[a];
`ifdef REGFILE_WB_BYPASS_EN
      // Forward the writeback value being committed this edge.
      if (wr_ok && (wr_addr == a)) src[i] = wr_ext;
`endif
      if (ZERO_REG && (a == '0)) src[i] = '0;
    end
  end

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_extend #(.DATA_W(DATA_W)) u_rd_nar (
        .data_i (src[g]),
        .size_i (rd_size[g*2 +: 2]),
        .sext_i (1'b0),
        .data_o (rd_data_d[g])
      );
      assign rd_data[g*DATA_W +: DATA_W] = rd_data_q[g];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      for (int i = 0; i < NUM_RD; i++) rd_data_q[i] <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_ext;
      for (int i = 0; i < NUM_RD; i++)
        if (rd_en[i]) rd_data_q[i] <= rd_data_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed-vector bench for regfile_multiport
// (DEPTH=24, two read ports).
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int DEPTH = 24;
  localparam int NRD = 2;
  localparam int AW = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NRD-1:0] rd_en = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*2-1:0]  rd_size = '0;
  logic [NRD*DW-1:0] rd_data;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [1:0]     wr_size = '0;
  logic           wr_sext = 1'b0;

  int tests = 0;
  int fails = 0;

  regfile_multiport #(
    .DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_size(rd_size), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .wr_sext(wr_sext)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] s, input logic x);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = s; wr_sext = x;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a,
                        input logic [1:0] s);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
    rd_size[p*2 +: 2] = s;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] s, input logic x);
    set_wr(a, d, s, x);
    tick();
    idle();
  endtask

  task automatic read(input int p, input logic [AW-1:0] a,
                      input logic [1:0] s);
    set_rd(p, a, s);
    tick();
    idle();
  endtask

  function automatic logic [DW-1:0] port(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_wr(5'd8, 32'hDEADBEEF, 2'b00, 1'b0);
    tick();
    tick();
    idle();
    tests++;
    if (rd_data !== '0) begin
      fails++;
      $display("FAIL reset_out got %h want 0", rd_data);
    end
    #2 rst_n = 1'b1;
    read(0, 5'd8, 2'b00);
    tests++;
    if (port(0) !== 32'h0) begin
      fails++;
      $display("FAIL reset_reg8 got %h want 00000000", port(0));
    end
  endtask

  task automatic test_basic();
    write(5'd8, 32'h00000A12, 2'b00, 1'b0);
    set_rd(0, 5'd8, 2'b00);
    #2;
    tests++;
    if (port(0) !== 32'h0) begin
      fails++;
      $display("FAIL basic_early got %h want 00000000", port(0));
    end
    tick();
    idle();
    tests++;
    if (port(0) !== 32'h00000A12) begin
      fails++;
      $display("FAIL basic_read got %h want 00000a12", port(0));
    end
  endtask

  task automatic test_narrow_write();
    logic [DW-1:0] d [4];
    logic [1:0]    s [4];
    logic          x [4];
    logic [DW-1:0] e [4];
    d = '{32'h0FFFFF80, 32'h0FFFFF80, 32'h0FFFFF80, 32'h12347FFF};
    s = '{2'b10, 2'b10, 2'b01, 2'b01};
    x = '{1'b0, 1'b1, 1'b1, 1'b1};
    e = '{32'h00000080, 32'hFFFFFF80, 32'hFFFFFF80, 32'h00007FFF};
    for (int k = 0; k < 4; k++) begin
      write(5'd8, d[k], s[k], x[k]);
      read(1, 5'd8, 2'b00);
      tests++;
      if (port(1) !== e[k]) begin
        fails++;
        $display("FAIL narrow_wr%0d got %h want %h", k, port(1), e[k]);
      end
    end
  endtask

  task automatic test_store_narrow();
    write(5'd19, 32'h123456FF, 2'b00, 1'b1);
    set_rd(0, 5'd19, 2'b00);
    set_rd(1, 5'd19, 2'b10);
    tick();
    idle();
    tests++;
    if (port(0) !== 32'h123456FF) begin
      fails++;
      $display("FAIL st_word got %h want 123456ff", port(0));
    end
    tests++;
    if (port(1) !== 32'h000000FF) begin
      fails++;
      $display("FAIL st_byte got %h want 000000ff", port(1));
    end
    read(0, 5'd19, 2'b01);
    tests++;
    if (port(0) !== 32'h000056FF) begin
      fails++;
      $display("FAIL st_half got %h want 000056ff", port(0));
    end
    read(1, 5'd19, 2'b11);
    tests++;
    if (port(1) !== 32'h123456FF) begin
      fails++;
      $display("FAIL st_rsvd got %h want 123456ff", port(1));
    end
  endtask

  task automatic test_zero_range();
    set_wr(5'd0, 32'h55, 2'b00, 1'b0);
    set_rd(0, 5'd0, 2'b00);
    tick();
    idle();
    tests++;
    if (port(0) !== 32'h0) begin
      fails++;
      $display("FAIL zero_same got %h want 00000000", port(0));
    end
    read(0, 5'd0, 2'b00);
    tests++;
    if (port(0) !== 32'h0) begin
      fails++;
      $display("FAIL zero_after got %h want 00000000", port(0));
    end
    write(5'd30, 32'hCAFEF00D, 2'b00, 1'b0);
    set_rd(0, 5'd30, 2'b00);
    set_rd(1, 5'd6, 2'b00);
    tick();
    idle();
    tests++;
    if (port(0) !== 32'h0) begin
      fails++;
      $display("FAIL oob_read got %h want 00000000", port(0));
    end
    tests++;
    if (port(1) !== 32'h0) begin
      fails++;
      $display("FAIL oob_alias got %h want 00000000", port(1));
    end
    read(1, 5'd19, 2'b00);
    tests++;
    if (port(1) !== 32'h123456FF) begin
      fails++;
      $display("FAIL oob_keep got %h want 123456ff", port(1));
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_same;
`ifdef REGFILE_WB_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    write(5'd5, 32'h11, 2'b00, 1'b0);
    set_wr(5'd5, 32'h22, 2'b00, 1'b0);
    set_rd(0, 5'd5, 2'b00);
    tick();
    idle();
    tests++;
    if (port(0) !== exp_same) begin
      fails++;
      $display("FAIL rw_same got %h want %h", port(0), exp_same);
    end
    read(0, 5'd5, 2'b00);
    tests++;
    if (port(0) !== 32'h22) begin
      fails++;
      $display("FAIL rw_next got %h want 00000022", port(0));
    end
  endtask

  task automatic test_hold_reset();
    set_rd(0, 5'd19, 2'b00);
    set_rd(1, 5'd5, 2'b00);
    tick();
    idle();
    rd_addr = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (port(0) !== 32'h123456FF || port(1) !== 32'h22) begin
        fails++;
        $display("FAIL hold%0d got %h want 00000022123456ff", k, rd_data);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (rd_data !== '0) begin
      fails++;
      $display("FAIL async_rst got %h want 0", rd_data);
    end
    #1 rst_n = 1'b1;
    set_rd(0, 5'd19, 2'b00);
    set_rd(1, 5'd5, 2'b00);
    tick();
    idle();
    tests++;
    if (rd_data !== '0) begin
      fails++;
      $display("FAIL rst_regs got %h want 0", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_narrow_write();
    test_store_narrow();
    test_zero_range();
    test_bypass();
    test_hold_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor of the ID-stage 32x32 register file. It has N synchronous read ports, one write port, and byte/half/word access sizes with optional sign extension.
- Write-side narrowing serves lb/lbu/lh/lhu writeback. Read-side narrowing serves sb/sh store data.
- Reads are registered with 1-cycle latency on the rising edge. Asynchronous reset clears all architectural state.
- Sits between the IF/ID pipeline register and the ID/EX register, and is fed by the WB stage.

Parameters:
- DATA_W, 32, register width in bits; must be >= 16.
- DEPTH, 32, number of registers; need not be a power of two.
- NUM_RD, 2, number of independent read ports; must be >= 1.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is writable.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Rd_en  in  NUM_RD  per-port read enable.
- Rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies [i*AW +: AW].
- Rd_size  in  NUM_RD*2  per-port read size: 00 word, 01 half, 10 byte, 11 = word.
- Rd_data  out  NUM_RD*DATA_W  registered read data; port i occupies [i*DATA_W +: DATA_W].
- Wr_en  in  1  write enable.
- Wr_addr  in  AW  write address.
- Wr_data  in  DATA_W  write data, before narrowing.
- Wr_size  in  2  write size, same encoding as Rd_size.
- Wr_sext  in  1  1 = sign-extend narrow writes; 0 = zero-extend.

Behaviour:
- Reset, asserted asynchronously while Rst_n=0:
  - all DEPTH registers are cleared to 0;
  - all Rd_data outputs are 0.
  - On release, the first rising edge operates normally.
- Write, on the rising edge when Wr_en=1:
  - reg[Wr_addr] <= ext(Wr_data, Wr_size, Wr_sext).
  - Byte mode keeps bits [7:0]; half mode keeps bits [15:0].
  - Upper bits are filled with the sign bit of the kept field when Wr_sext=1, otherwise with zeros.
  - Word mode and size 11 write all DATA_W bits unchanged.
- Write suppression (the register does not change and nothing is flagged):
  - Wr_addr==0 when ZERO_REG=1;
  - Wr_addr>=DEPTH.
- Read, on the rising edge when Rd_en[i]=1:
  - Rd_data[i] <= rnarrow(src, Rd_size[i]).
  - rnarrow zero-extends the low 8 bits (byte) or low 16 bits (half); word passes all bits.
  - src is reg[Rd_addr[i]], or the bypass value described under Optional Feature.
  - When Rd_en[i]=0, Rd_data[i] holds its previous value.
  - Latency is exactly 1 cycle from address to data.
- Read boundary cases:
  - Rd_addr==0 with ZERO_REG=1 reads 0, even if a write to 0 is attempted the same cycle.
  - Rd_addr>=DEPTH reads 0.
- Simultaneous events:
  - Any number of ports may read the same address in one cycle, each with its own size.
  - A read and a write to the same address in the same cycle are resolved by the Optional Feature.
  - If Rst_n falls mid-cycle, it overrides any pending write or read; no partial update is allowed.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - when Wr_en=1, Wr_addr==Rd_addr[i], Rd_en[i]=1 and the write is not suppressed, src is the extended write value ext(Wr_data, Wr_size, Wr_sext);
  - read narrowing is then applied to that value.
  - The read therefore returns the new value in the same cycle as the write.
- Undefined:
  - src is always the pre-edge register content, i.e. the old value;
  - the new value is visible from the next read onward.

Decomposition:
- Package regfile_pkg holds:
  - localparams SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10, SZ_RSVD=2'b11;
  - a function size_ext(data, size, sext) used for both write extension and read narrowing (read narrowing uses sext=0).
- One sub-module, regfile_extend:
  - combinational, parametrised by DATA_W;
  - instantiated once on the write path and once per read port via a generate loop.
- Storage is a flop array in the top module.

Test Plan:
- Reset and basic read: hold Rst_n=0, write 0xDEADBEEF to reg 8, release, read port 0 addr 8 word → 0x00000000. Then write 0x00000A12 to reg 8; the next read of reg 8 returns 0x00000A12 exactly one edge after the address is presented.
- Narrow writes: Wr_data=0x0FFFFF80 to reg 8, byte, sext=0 → reg 8 = 0x00000080. Same with sext=1 → 0xFFFFFF80. Half with sext=1 → 0xFFFFFF80. Wr_data=0x12347FFF half with sext=1 → 0x00007FFF.
- Store narrowing across ports: reg 19 = 0x123456FF. In one cycle read port 0 word, port 1 byte, both addr 19 → 0x123456FF and 0x000000FF. Half read of reg 19 → 0x000056FF.
- Zero register and range: write 0x55 to reg 0 while reading reg 0 the same cycle → Rd_data=0, reg 0 stays 0. With DEPTH=24, write to addr 30 → no register changes; read of addr 30 → 0.
- Same-cycle read/write: reg 5 = 0x11, then write 0x22 to reg 5 while reading reg 5. With REGFILE_WB_BYPASS_EN defined → 0x22; undefined → 0x11, and the next read → 0x22.
- Hold and mid-operation reset: with Rd_en=0 for 3 cycles, Rd_data is unchanged. Asserting Rst_n=0 between edges clears Rd_data and all registers immediately, without waiting for a clock edge.
